// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: machine-mode trap/interrupt sequencer. It owns the single
// CSR write port.
//   - Normal operation: instruction CSR writes pass straight through.
//   - Enabled interrupt: writes mepc, then mcause, then mstatus, and then
//     redirects fetch to the trap vector.
//   - mret: restores mstatus and redirects fetch to mepc.
//
// Optional feature: define TRAP_VECTORED_EN for vectored trap entry, where
// redirect_pc = MTVEC_BASE + cause*4. With it undefined, all causes go to
// MTVEC_BASE (direct mode).
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   irq_ext, irq_timer    level interrupt requests
//   mstatus_in, mie_in,   CSR file readback
//   epc_in
//   pc_in                 PC of the instruction in execute
//   is_mret               execute instruction is mret
//   inst_csr_wr/addr/     CSR write request from the execute instruction
//   wdata
//   csr_wr/waddr/wdata    write port into the CSR file
//   stall                 hold fetch/decode/execute
//   redirect/redirect_pc  one-cycle flush and PC load
module csr_trap_ctrl #(
  parameter logic [31:0] MTVEC_BASE = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mie_in,
  input  logic [31:0] epc_in,
  input  logic [31:0] pc_in,
  input  logic        is_mret,
  input  logic        inst_csr_wr,
  input  logic [11:0] inst_csr_addr,
  input  logic [31:0] inst_csr_wdata,
  output logic        csr_wr,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] T_EPC    = 3'd1;
  localparam logic [2:0] T_CAUSE  = 3'd2;
  localparam logic [2:0] T_STATUS = 3'd3;
  localparam logic [2:0] T_JUMP   = 3'd4;
  localparam logic [2:0] R_STATUS = 3'd5;
  localparam logic [2:0] R_JUMP   = 3'd6;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
  } csr_wport_t;

  logic [2:0]  state, state_nxt;
  logic [31:0] epc_q;
  logic [3:0]  cause_q;
  logic        ext_en, pend;
  logic [31:0] trap_vec;
  logic [31:0] st_entry, st_ret;
  csr_wport_t  wp;

  // Only the MEIE/MTIE enable bits matter here.
  logic unused_mie;
  assign unused_mie = ^{mie_in[31:12], mie_in[10:8], mie_in[6:0]};

  assign ext_en = irq_ext & mie_in[11];
  assign pend   = mstatus_in[3] & (ext_en | (irq_timer & mie_in[7]));

`ifdef TRAP_VECTORED_EN
  assign trap_vec = MTVEC_BASE + {26'b0, cause_q, 2'b00};
`else
  assign trap_vec = MTVEC_BASE;
`endif

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
  always_comb begin
    st_entry        = mstatus_in;
    st_entry[7]     = mstatus_in[3];
    st_entry[3]     = 1'b0;
    st_entry[12:11] = 2'b11;
  end

  // mret: MIE <= MPIE, MPIE <= 1, MPP left alone.
  always_comb begin
    st_ret    = mstatus_in;
    st_ret[3] = mstatus_in[7];
    st_ret[7] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pend) begin
        epc_q   <= pc_in;
        cause_q <= ext_en ? 4'd11 : 4'd7;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pend)         state_nxt = T_EPC;
        else if (is_mret) state_nxt = R_STATUS;
      end
      T_EPC:    state_nxt = T_CAUSE;
      T_CAUSE:  state_nxt = T_STATUS;
      T_STATUS: state_nxt = T_JUMP;
      T_JUMP:   state_nxt = IDLE;
      R_STATUS: state_nxt = R_JUMP;
      R_JUMP:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wp          = '0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    case (state)
      IDLE: begin
        // The pass-through is suppressed on the decision cycle, so the
        // interrupted or mret instruction never commits its CSR write.
        if (pend || is_mret) stall = 1'b1;
        else                 wp    = '{inst_csr_wr, inst_csr_addr, inst_csr_wdata};
      end
      T_EPC: begin
        wp    = '{1'b1, A_MEPC, epc_q};
        stall = 1'b1;
      end
      T_CAUSE: begin
        wp    = '{1'b1, A_MCAUSE, {1'b1, 27'b0, cause_q}};
        stall = 1'b1;
      end
      T_STATUS: begin
        wp    = '{1'b1, A_MSTATUS, st_entry};
        stall = 1'b1;
      end
      T_JUMP: begin
        redirect    = 1'b1;
        redirect_pc = trap_vec;
      end
      R_STATUS: begin
        wp    = '{1'b1, A_MSTATUS, st_ret};
        stall = 1'b1;
      end
      R_JUMP: begin
        redirect    = 1'b1;
        redirect_pc = epc_in;
      end
      default: ;
    endcase
    // The IDLE terms are combinational, so they are gated here. This keeps
    // every output at 0 for the whole time reset is held.
    if (!rst) begin
      wp          = '0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
    end
  end

  assign csr_wr    = wp.wr;
  assign csr_waddr = wp.addr;
  assign csr_wdata = wp.data;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl. Each cycle drives its inputs at
// posedge+1 and pushes the expected outputs. It pops and compares at the
// following negedge.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq_ext, irq_timer;
  logic [31:0] mstatus_in, mie_in, epc_in, pc_in;
  logic        is_mret, inst_csr_wr;
  logic [11:0] inst_csr_addr;
  logic [31:0] inst_csr_wdata;
  logic        csr_wr, stall, redirect;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;

  always #5 clk = ~clk;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] VEC_EXT = 32'h0000_012C;
  localparam logic [31:0] VEC_TMR = 32'h0000_011C;
`else
  localparam logic [31:0] VEC_EXT = 32'h0000_0100;
  localparam logic [31:0] VEC_TMR = 32'h0000_0100;
`endif

  csr_trap_ctrl #(.MTVEC_BASE(32'h0000_0100)) dut (
    .clk(clk), .rst(rst),
    .irq_ext(irq_ext), .irq_timer(irq_timer),
    .mstatus_in(mstatus_in), .mie_in(mie_in), .epc_in(epc_in), .pc_in(pc_in),
    .is_mret(is_mret), .inst_csr_wr(inst_csr_wr),
    .inst_csr_addr(inst_csr_addr), .inst_csr_wdata(inst_csr_wdata),
    .csr_wr(csr_wr), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct {
    string       tag;
    logic        wr;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        st;
    logic        rd;
    logic [31:0] rpc;
  } exp_t;

  exp_t sbq[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Expect outputs for the current cycle. Returns at posedge+1, ready to
  // drive the next cycle.
  task automatic tick(input string tag, input logic wr, input logic [11:0] a,
                      input logic [31:0] d, input logic st, input logic rd,
                      input logic [31:0] rpc);
    exp_t e;
    e.tag = tag; e.wr = wr; e.waddr = a; e.wdata = d;
    e.st = st; e.rd = rd; e.rpc = rpc;
    sbq.push_back(e);
    @(negedge clk);
    e = sbq.pop_front();
    chk({e.tag, ".wr"},    32'(csr_wr),    32'(e.wr));
    chk({e.tag, ".addr"},  32'(csr_waddr), 32'(e.waddr));
    chk({e.tag, ".data"},  csr_wdata,      e.wdata);
    chk({e.tag, ".stall"}, 32'(stall),     32'(e.st));
    chk({e.tag, ".redir"}, 32'(redirect),  32'(e.rd));
    chk({e.tag, ".rpc"},   redirect_pc,    e.rpc);
    @(posedge clk);
    #1;
  endtask

  task automatic zeros(input string tag);
    tick(tag, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Full interrupt entry from a pending IDLE cycle. Interrupts stay asserted
  // through the sequence and drop on the jump cycle.
  task automatic trap_seq(input string tag, input logic [31:0] pc,
                          input logic [31:0] cause, input logic [31:0] st,
                          input logic [31:0] vec);
    tick({tag, ".c0"}, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0);
    tick({tag, ".c1"}, 1'b1, 12'h341, pc,    1'b1, 1'b0, 32'h0);
    tick({tag, ".c2"}, 1'b1, 12'h342, cause, 1'b1, 1'b0, 32'h0);
    tick({tag, ".c3"}, 1'b1, 12'h300, st,    1'b1, 1'b0, 32'h0);
    irq_ext = 1'b0; irq_timer = 1'b0; is_mret = 1'b0;
    tick({tag, ".c4"}, 1'b0, 12'h000, 32'h0, 1'b0, 1'b1, vec);
  endtask

  initial begin
    rst = 1'b0; irq_ext = 1'b1; irq_timer = 1'b0;
    mstatus_in = 32'h8; mie_in = 32'h800; epc_in = '0; pc_in = 32'h40;
    is_mret = 1'b0; inst_csr_wr = 1'b1;
    inst_csr_addr = 12'h304; inst_csr_wdata = 32'h800;
    @(posedge clk); #1;

    // Reset held with a pending interrupt and an instruction write present.
    for (int i = 0; i < 3; i++) zeros("rst");
    rst = 1'b1; irq_ext = 1'b0; inst_csr_wr = 1'b0;
    inst_csr_addr = '0; inst_csr_wdata = '0;
    zeros("rst_rel");

    // External trap
    mstatus_in = 32'h8; mie_in = 32'h800; pc_in = 32'h40; irq_ext = 1'b1;
    trap_seq("ext", 32'h40, 32'h8000_000B, 32'h1880, VEC_EXT);
    zeros("ext_idle");

    // Both pending: external wins
    mie_in = 32'h880; pc_in = 32'h50; irq_ext = 1'b1; irq_timer = 1'b1;
    trap_seq("both", 32'h50, 32'h8000_000B, 32'h1880, VEC_EXT);

    // Timer only
    pc_in = 32'h60; irq_timer = 1'b1;
    trap_seq("tmr", 32'h60, 32'h8000_0007, 32'h1880, VEC_TMR);

    // Globally masked: the instruction write passes through the same cycle.
    mstatus_in = 32'h0; mie_in = 32'h800; irq_ext = 1'b1;
    inst_csr_wr = 1'b1; inst_csr_addr = 12'h304; inst_csr_wdata = 32'h800;
    tick("mask_g", 1'b1, 12'h304, 32'h800, 1'b0, 1'b0, 32'h0);
    // Only timer enabled, external pending: no trap.
    mstatus_in = 32'h8; mie_in = 32'h080;
    inst_csr_addr = 12'h341; inst_csr_wdata = 32'hABCD_0000;
    tick("mask_e", 1'b1, 12'h341, 32'hABCD_0000, 1'b0, 1'b0, 32'h0);
    irq_ext = 1'b0; inst_csr_wr = 1'b0; inst_csr_addr = '0; inst_csr_wdata = '0;
    zeros("mask_idle");

    // mret
    mstatus_in = 32'h1880; epc_in = 32'h44; is_mret = 1'b1;
    tick("mret.c0", 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0);
    is_mret = 1'b0;
    tick("mret.c1", 1'b1, 12'h300, 32'h1888, 1'b1, 1'b0, 32'h0);
    tick("mret.c2", 1'b0, 12'h000, 32'h0, 1'b0, 1'b1, 32'h44);
    zeros("mret_idle");

    // Interrupt beats mret in the same cycle.
    mstatus_in = 32'h8; mie_in = 32'h800; pc_in = 32'h70;
    irq_ext = 1'b1; is_mret = 1'b1;
    trap_seq("prio", 32'h70, 32'h8000_000B, 32'h1880, VEC_EXT);

    // Reset arriving during T_CAUSE abandons the sequence.
    pc_in = 32'h80; irq_ext = 1'b1;
    tick("rmid.c0", 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0);
    tick("rmid.c1", 1'b1, 12'h341, 32'h80, 1'b1, 1'b0, 32'h0);
    rst = 1'b0; irq_ext = 1'b0;
    zeros("rmid.c2");
    rst = 1'b1;
    zeros("rmid.rel0");
    zeros("rmid.rel1");
    zeros("rmid.rel2");

    // Pass-through after reset proves the block is back in IDLE.
    inst_csr_wr = 1'b1; inst_csr_addr = 12'h300; inst_csr_wdata = 32'h5;
    tick("rmid.pass", 1'b1, 12'h300, 32'h5, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
